// File: rtl/la_maquina.sv
// la_maquina: sensor-query engine used as a CPU custom instruction.
//   A start strobe latches a command byte from dataa[7:0] and presents it on
//   SendUart. The engine then collects a two-byte response {data, check}
//   from ReadUart, validates it and reports a status code on result together
//   with a one-cycle done pulse. If the full response does not arrive within
//   TIMEOUT_CYCLES cycles, counted from SEND, result gets CODE_TIMEOUT.
// Ports:
//   clk       in   1   clock, rising edge
//   reset     in   1   synchronous, active-low reset
//   dataa     in   32  operand; only bits [7:0] (command byte) are used
//   enable    in   1   start strobe in IDLE, byte-valid strobe in the wait states
//   ReadUart  in   8   received UART byte, sampled on a strobe
//   SendUart  out  8   command byte toward UART TX; 0 when idle/finishing
//   result    out  8   status code, held until the next completion
//   done      out  1   one-cycle completion pulse
module la_maquina #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter logic [7:0]  CHK_KEY        = 8'h37,
    parameter logic [7:0]  CODE_TIMEOUT   = 8'h0C,
    parameter logic [7:0]  CODE_CHK_ERR   = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataa,
    input  logic        enable,
    input  logic [7:0]  ReadUart,
    output logic [7:0]  SendUart,
    output logic [7:0]  result,
    output logic        done
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_DATA,
        WAIT_CHK,
        FINISH
    } state_t;

    state_t        state, state_n;
    logic          enable_q;
    logic          strobe;
    logic [7:0]    cmd;
    logic [7:0]    data;
    logic [CW-1:0] cnt;
    logic          timed_out;

    logic          ld_cmd, ld_data, ld_res, cnt_clr, cnt_run;
    logic [7:0]    res_n;

    // Upper operand bits carry no meaning for this instruction.
    logic unused_dataa;
    assign unused_dataa = ^dataa[31:8];

    assign strobe    = enable & ~enable_q;
    assign timed_out = (cnt == TLIM);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            enable_q <= 1'b0;
            cmd      <= '0;
            data     <= '0;
            cnt      <= '0;
            result   <= '0;
        end else begin
            state    <= state_n;
            enable_q <= enable;
            if (ld_cmd)  cmd    <= dataa[7:0];
            if (ld_data) data   <= ReadUart;
            if (ld_res)  result <= res_n;
            // Counter saturates at the limit so a data byte accepted exactly
            // on the timeout cycle still leads to a timeout in WAIT_CHK.
            if (cnt_clr)
                cnt <= '0;
            else if (cnt_run && !timed_out)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_n  = state;
        SendUart = '0;
        done     = 1'b0;
        ld_cmd   = 1'b0;
        ld_data  = 1'b0;
        ld_res   = 1'b0;
        res_n    = result;
        cnt_clr  = 1'b0;
        cnt_run  = 1'b0;
        case (state)
            IDLE: begin
                if (strobe) begin
                    ld_cmd  = 1'b1;
                    cnt_clr = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                SendUart = cmd;
                cnt_run  = 1'b1;
                if (timed_out) begin
                    ld_res  = 1'b1;
                    res_n   = CODE_TIMEOUT;
                    state_n = FINISH;
                end else begin
                    state_n = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                SendUart = cmd;
                cnt_run  = 1'b1;
                if (strobe) begin
                    ld_data = 1'b1;
                    state_n = WAIT_CHK;
                end else if (timed_out) begin
                    ld_res  = 1'b1;
                    res_n   = CODE_TIMEOUT;
                    state_n = FINISH;
                end
            end
            WAIT_CHK: begin
                SendUart = cmd;
                cnt_run  = 1'b1;
                if (strobe) begin
                    ld_res  = 1'b1;
                    res_n   = (ReadUart == (data ^ CHK_KEY)) ? data : CODE_CHK_ERR;
                    state_n = FINISH;
                end else if (timed_out) begin
                    ld_res  = 1'b1;
                    res_n   = CODE_TIMEOUT;
                    state_n = FINISH;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_la_maquina.sv
// Self-checking bench for la_maquina (TIMEOUT_CYCLES overridden to 16).
module tb_la_maquina;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataa;
    logic        enable;
    logic [7:0]  ReadUart;
    logic [7:0]  SendUart;
    logic [7:0]  result;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    la_maquina #(.TIMEOUT_CYCLES(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .dataa    (dataa),
        .enable   (enable),
        .ReadUart (ReadUart),
        .SendUart (SendUart),
        .result   (result),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
        logic [7:0]  c;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: response is valid when the check byte is data XOR key.
    function automatic logic [7:0] ref_result(input logic [7:0] d, input logic [7:0] c);
        return (c == (d ^ 8'h37)) ? d : 8'hFF;
    endfunction

    // Leaves us at the negedge where the DUT is in SEND, enable low.
    task automatic start(input logic [31:0] a);
        @(negedge clk);
        dataa  = a;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        chk("send_cmd", SendUart, a[7:0]);
        chk("send_nodone", done, 0);
    endtask

    task automatic strobe_byte(input logic [7:0] cmd, input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        chk("wait_cmd", SendUart, cmd);
        chk("wait_nodone", done, 0);
        ReadUart = b;
        enable   = 1'b1;
        @(negedge clk);
        enable   = 1'b0;
    endtask

    task automatic txn(input logic [31:0] a, input logic [7:0] d, input logic [7:0] c,
                       input int g1, input int g2, input logic [7:0] exp);
        start(a);
        strobe_byte(a[7:0], d, g1);
        strobe_byte(a[7:0], c, g2);
        chk("fin_done", done, 1);
        chk("fin_result", result, exp);
        chk("fin_send0", SendUart, 0);
        @(negedge clk);
        chk("post_done", done, 0);
        chk("post_result", result, exp);
    endtask

    // Negedge k observes cycle SEND+k-1; done expected at k = 17.
    task automatic timeout_run(input logic [31:0] a, input bit send_d, input int chk_at,
                               input logic [7:0] d, input logic [7:0] exp);
        int k;
        start(a);
        k = 1;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (done) break;
            if (k == 16) chk("to_send_hold", SendUart, a[7:0]);
            if (send_d && k == 2) begin ReadUart = d; enable = 1'b1; end
            if (send_d && k == 3) enable = 1'b0;
            if (k == chk_at) begin ReadUart = d ^ 8'h37; enable = 1'b1; end
            if (k == chk_at + 1) enable = 1'b0;
        end
        enable = 1'b0;
        chk("to_done_at", k, 17);
        chk("to_result", result, exp);
        chk("to_send0", SendUart, 0);
        @(negedge clk);
        chk("to_post_done", done, 0);
    endtask

    initial begin
        tbl[0] = '{32'h0000_0001, 8'h0A, 8'h3D, 8'h0A};
        tbl[1] = '{32'h0000_0002, 8'h07, 8'h30, 8'h07};
        tbl[2] = '{32'h0000_0003, 8'h00, 8'h37, 8'h00};
        tbl[3] = '{32'h0000_0004, 8'h0A, 8'h00, 8'hFF};
        tbl[4] = '{32'hABCD_EF55, 8'h0C, 8'h3B, 8'h0C};

        reset = 1'b0; enable = 1'b0; dataa = '0; ReadUart = '0;
        repeat (2) @(negedge clk);
        chk("rst_send", SendUart, 0);
        chk("rst_result", result, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_send", SendUart, 0);

        for (int i = 0; i < 5; i++)
            txn(tbl[i].a, tbl[i].d, tbl[i].c, i % 3, (i + 1) % 3, tbl[i].exp);

        // Randomized transactions against the reference rule.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [7:0]  d, c;
            a = $urandom;
            d = 8'($urandom);
            c = ($urandom_range(0, 1) == 1) ? (d ^ 8'h37) : 8'($urandom);
            txn(a, d, c, $urandom_range(0, 3), $urandom_range(0, 3), ref_result(d, c));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Timeouts: no bytes, data only, check strobe exactly on the limit cycle.
        timeout_run(32'h21, 1'b0, 0, 8'h00, 8'h0C);
        timeout_run(32'h22, 1'b1, 0, 8'h5A, 8'h0C);
        timeout_run(32'h23, 1'b1, 16, 8'h0A, 8'h0A);

        // Enable held high: exactly one start, ending in timeout.
        begin
            int ndone;
            ndone = 0;
            @(negedge clk);
            dataa  = 32'h05;
            enable = 1'b1;
            repeat (25) begin
                @(negedge clk);
                if (done) ndone++;
            end
            chk("held_send_idle", SendUart, 0);
            enable = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (done) ndone++;
            end
            chk("held_ndone", ndone, 1);
            chk("held_result", result, 8'h0C);
        end

        // Reset in WAIT_CHK aborts without done.
        begin
            int ndone;
            ndone = 0;
            start(32'h06);
            strobe_byte(8'h06, 8'h11, 0);
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            chk("abort_send", SendUart, 0);
            chk("abort_result", result, 0);
            repeat (4) begin
                if (done) ndone++;
                @(negedge clk);
            end
            chk("abort_ndone", ndone, 0);
            txn(32'h07, 8'h0A, 8'h3D, 1, 0, 8'h0A);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
